tile_pingpong_fb: RTL
=====================

Name: tile_pingpong_fb

Overview:
- Parametrised double-buffered tile framebuffer between the tile renderer (writer) and the VGA scan-out path (reader).
- Holds two banks of COLS*ROWS tile entries. The writer fills the back bank; the reader maps pixel coordinates to tile entries in the front bank.
- Banks swap only at a frame start, and only after the writer has signalled completion. This adds a writer handshake, a frame-drop counter, out-of-range blanking and a registered read path.

Parameters:
- DATA_W, 8, bits per tile entry
- COORD_W, 10, width of pixel h/v coordinates
- TILE_W, 40, tile width in pixels
- TILE_H, 24, tile height in pixels
- COLS, 16, tiles per row
- ROWS, 20, tile rows
- BLANK, 0, rd_data value for coordinates outside the grid
- Derived, not overridable: DEPTH = COLS*ROWS; ADDR_W = clog2(DEPTH)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  tile index to write
- wr_data  in  DATA_W  tile data
- wr_done  in  1  one-cycle pulse: back bank complete
- wr_ready  out  1  writes accepted this cycle
- rd_h  in  COORD_W  current pixel column
- rd_v  in  COORD_W  current pixel row
- rd_data  out  DATA_W  tile data, 1-cycle latency
- rd_valid  out  1  rd_data corresponds to an in-grid coordinate
- front_sel  out  1  0 = bank A is front, 1 = bank B is front
- drop_count  out  16  frames where no swap occurred (writer not done), saturating

Behaviour:
- Reset (async assert, sync deassert inside the block): front_sel=0, state=FILL, wr_ready=1, rd_data=BLANK, rd_valid=0, drop_count=0. RAM contents are undefined.
- Frame start (fs): the cycle where rd_h==0 && rd_v==0 and the previous cycle did not satisfy the same condition. This is edge-qualified, so a stall holding (0,0) for several cycles produces exactly one fs.
- State FILL:
  - wr_ready=1.
  - A write with wr_en=1 and wr_addr<DEPTH writes the back bank. A write with wr_addr>=DEPTH is ignored.
  - wr_done moves the state to READY.
  - fs without wr_done: no swap, drop_count increments (saturates at 0xFFFF).
- State READY:
  - wr_ready=0. wr_en is ignored. A further wr_done is ignored.
  - On fs: front_sel toggles and the state returns to FILL.
- Simultaneous wr_done and fs in FILL:
  - The swap happens on that edge; the state stays FILL with the new back bank. No drop is counted.
  - A write in the same cycle commits to the old back bank, which becomes front.
- Swap timing:
  - The read addressed in the fs cycle uses the old front bank.
  - Reads from the next cycle on use the new front bank.
  - The new back bank is writable from the next cycle.
- Read path:
  - Tile index = (rd_h/TILE_W) + (rd_v/TILE_H)*COLS. Division is by constants; the index is computed at width ADDR_W+1 so it cannot overflow.
  - In-grid test: rd_h < COLS*TILE_W and rd_v < ROWS*TILE_H.
  - rd_data and rd_valid are registered: values reflect the coordinates one cycle earlier.
  - Out of grid: rd_data=BLANK, rd_valid=0, no RAM-dependent value.
- Banks are inferred synchronous single-port RAMs, one write port (writer) and one read port (reader) routed by front_sel. The same bank is never read and written in the same cycle.
- Reset mid-fill: the state returns to FILL with front_sel=0. Partial back-bank data is kept but not trusted; the writer restarts.

Test Plan:
- Reset, then fill bank B (front_sel=0) with wr_data=addr for addr 0..319, pulse wr_done, drive (0,0) -> front_sel=1 on the edge after fs; rd_h=85,rd_v=50 -> tile 2+2*16=34, rd_data=34 one cycle later, rd_valid=1.
- No wr_done before 3 consecutive frame starts -> front_sel unchanged, drop_count=3. Hold (0,0) for 5 cycles -> only one increment.
- In READY, wr_en=1 wr_addr=5 wr_data=0xAA -> wr_ready=0, back bank entry 5 unchanged after the next swap cycle.
- wr_done and fs in the same cycle with a write to addr 7 data 0x3C -> swap with drop_count unchanged; a read of tile 7 (rd_h=280,rd_v=0) returns 0x3C.
- rd_h=640 or rd_v=480 -> rd_data=BLANK, rd_valid=0. rd_h=639,rd_v=479 -> tile 319, rd_valid=1.
- Assert rst_n=0 mid-fill with front_sel=1 -> front_sel=0, rd_data=BLANK, wr_ready=1 immediately, asynchronously, with no clock edge.

Source files
------------

// File: rtl/tile_pingpong_fb_if.sv
// ---------------------------------------------------------------------------
// tile_pingpong_fb_if
//   Bundles the writer handshake and the scan-out read bus of the
//   double-buffered tile framebuffer.
//
//   Parameters : ADDR_W  tile index width (clog2 of COLS*ROWS)
//                DATA_W  bits per tile entry
//                COORD_W pixel coordinate width
//
//   Signals    : wr_en, wr_addr, wr_data, wr_done  writer -> framebuffer
//                wr_ready                          framebuffer -> writer
//                rd_h, rd_v                        scan-out -> framebuffer
//                rd_data, rd_valid                 framebuffer -> scan-out
//                front_sel, drop_count             framebuffer status
//
//   Modports   : master  drives the writer/scan-out side (renderer, bench)
//                slave   the framebuffer itself
// ---------------------------------------------------------------------------
interface tile_pingpong_fb_if #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int COORD_W = 10
);
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_done;
  logic               wr_ready;
  logic [COORD_W-1:0] rd_h;
  logic [COORD_W-1:0] rd_v;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               front_sel;
  logic [15:0]        drop_count;

  modport master (
    output wr_en, wr_addr, wr_data, wr_done, rd_h, rd_v,
    input  wr_ready, rd_data, rd_valid, front_sel, drop_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done, rd_h, rd_v,
    output wr_ready, rd_data, rd_valid, front_sel, drop_count
  );
endinterface

// File: rtl/tile_pingpong_fb.sv
// ---------------------------------------------------------------------------
// tile_pingpong_fb
//   Double-buffered tile framebuffer sitting between the tile renderer and
//   the VGA scan-out path. Two banks of COLS*ROWS entries: the renderer
//   fills the back bank, scan-out reads the front bank. Banks swap only on
//   a frame start (first cycle at pixel (0,0)) and only once the renderer
//   has pulsed wr_done; frame starts that find the renderer unfinished are
//   counted in a saturating drop counter.
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset (deassertion is synchronised
//            internally)
//     bus    tile_pingpong_fb_if.slave:
//              wr_en/wr_addr/wr_data  write into the back bank (FILL only)
//              wr_done                back bank complete, arms the swap
//              wr_ready               writes are accepted this cycle
//              rd_h/rd_v              current pixel coordinate
//              rd_data/rd_valid       tile entry, one cycle later; BLANK and
//                                     invalid outside the tile grid
//              front_sel              0: bank A is front, 1: bank B is front
//              drop_count             frame starts without a swap, saturating
// ---------------------------------------------------------------------------
module tile_pingpong_fb #(
  parameter int                DATA_W  = 8,
  parameter int                COORD_W = 10,
  parameter int                TILE_W  = 40,
  parameter int                TILE_H  = 24,
  parameter int                COLS    = 16,
  parameter int                ROWS    = 20,
  parameter logic [DATA_W-1:0] BLANK   = '0
) (
  input logic               clk,
  input logic               rst_n,
  tile_pingpong_fb_if.slave bus
);

  localparam int DEPTH   = COLS * ROWS;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int H_LIMIT = COLS * TILE_W;
  localparam int V_LIMIT = ROWS * TILE_H;

  localparam logic [COORD_W-1:0] TILE_W_C = COORD_W'(TILE_W);
  localparam logic [COORD_W-1:0] TILE_H_C = COORD_W'(TILE_H);
  localparam logic [ADDR_W:0]    COLS_C   = (ADDR_W + 1)'(COLS);
  localparam logic [ADDR_W:0]    DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  // -------------------------------------------------------------------------
  // Reset synchroniser: assertion reaches every flop immediately, release
  // is delayed by two clock edges so all state leaves reset on the same edge.
  // -------------------------------------------------------------------------
  logic [1:0] rstPipe;
  logic       rstInt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstPipe <= 2'b00;
    end else begin
      rstPipe <= {rstPipe[0], 1'b1};
    end
  end

  assign rstInt = rstPipe[1];

  // -------------------------------------------------------------------------
  // Frame start: rising edge of "coordinate is (0,0)", so a stalled scan-out
  // parked on the origin yields a single frame start.
  // -------------------------------------------------------------------------
  logic atOrigin;
  logic atOriginPrev;
  logic fs;

  assign atOrigin = (bus.rd_h == '0) && (bus.rd_v == '0);
  assign fs       = atOrigin && !atOriginPrev;

  // -------------------------------------------------------------------------
  // Swap control FSM
  //   FILL  : renderer writes the back bank; wr_done arms the swap
  //   READY : back bank frozen until the next frame start swaps it in
  // -------------------------------------------------------------------------
  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t      stateReg;
  state_t      stateNext;
  logic        frontSelReg;
  logic [15:0] dropCountReg;
  logic        swap;
  logic        dropInc;
  logic        wrAccept;
  logic        wrAddrOk;

  assign wrAddrOk = (32'(bus.wr_addr) < DEPTH);

  always_comb begin
    stateNext = stateReg;
    swap      = 1'b0;
    dropInc   = 1'b0;
    wrAccept  = 1'b0;
    case (stateReg)
      FILL: begin
        wrAccept = bus.wr_en && wrAddrOk;
        if (fs) begin
          // wr_done coinciding with the frame start swaps straight away and
          // the freshly exposed back bank is immediately open for writing.
          if (bus.wr_done) begin
            swap = 1'b1;
          end else begin
            dropInc = 1'b1;
          end
        end else if (bus.wr_done) begin
          stateNext = READY;
        end
      end
      READY: begin
        if (fs) begin
          swap      = 1'b1;
          stateNext = FILL;
        end
      end
      default: begin
        stateNext = FILL;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Read address generation. Tile index is kept one bit wider than the RAM
  // address so the column/row sum can never wrap into a valid entry.
  // -------------------------------------------------------------------------
  logic [COORD_W-1:0] tileCol;
  logic [COORD_W-1:0] tileRow;
  logic [ADDR_W:0]    tileIdx;
  logic [ADDR_W-1:0]  rdAddr;
  logic               rdInGrid;

  assign tileCol  = bus.rd_h / TILE_W_C;
  assign tileRow  = bus.rd_v / TILE_H_C;
  assign tileIdx  = (ADDR_W + 1)'(tileCol) + (ADDR_W + 1)'(tileRow) * COLS_C;
  assign rdAddr   = tileIdx[ADDR_W-1:0];
  assign rdInGrid = (32'(bus.rd_h) < H_LIMIT) &&
                    (32'(bus.rd_v) < V_LIMIT) &&
                    (tileIdx < DEPTH_C);

  // -------------------------------------------------------------------------
  // Control state registers
  // -------------------------------------------------------------------------
  logic rdValidReg;
  logic rdSelReg;

  always_ff @(posedge clk or negedge rstInt) begin
    if (!rstInt) begin
      stateReg     <= FILL;
      frontSelReg  <= 1'b0;
      dropCountReg <= '0;
      atOriginPrev <= 1'b0;
      rdValidReg   <= 1'b0;
      rdSelReg     <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      atOriginPrev <= atOrigin;
      if (swap) begin
        frontSelReg <= ~frontSelReg;
      end
      if (dropInc && (dropCountReg != 16'hFFFF)) begin
        dropCountReg <= dropCountReg + 16'd1;
      end
      // The read launched this cycle comes from the current (pre-swap)
      // front bank; remember which bank answers it.
      rdValidReg <= rdInGrid;
      rdSelReg   <= frontSelReg;
    end
  end

  // -------------------------------------------------------------------------
  // Banks: index 0 = bank A, index 1 = bank B. Each is a plain synchronous
  // RAM; the back bank only sees writes and the front bank only sees reads,
  // so neither bank is ever read and written in the same cycle.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] bankQ [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gBank
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] q;
      logic              isFront;

      assign isFront = (frontSelReg == 1'(gi));

      always_ff @(posedge clk) begin
        if (wrAccept && !isFront) begin
          mem[bus.wr_addr] <= bus.wr_data;
        end
        if (rdInGrid && isFront) begin
          q <= mem[rdAddr];
        end
      end

      assign bankQ[gi] = q;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Outputs. rd_data is forced to BLANK whenever the registered coordinate
  // was off-grid, which also covers the cycle right after reset.
  // -------------------------------------------------------------------------
  assign bus.rd_data    = rdValidReg ? bankQ[rdSelReg] : BLANK;
  assign bus.rd_valid   = rdValidReg;
  assign bus.wr_ready   = (stateReg == FILL);
  assign bus.front_sel  = frontSelReg;
  assign bus.drop_count = dropCountReg;

endmodule
